serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 The block SHALL have port sub  input  1  0 = add, 1 = subtract (a_in - b_in); sampled with start.
REQ-006 The block SHALL have port a_in  input  WIDTH  operand A; sampled with start.
REQ-007 The block SHALL have port b_in  input  WIDTH  operand B; sampled with start.
REQ-008 The block SHALL have port busy  output  1  high while bits are being processed (state RUN).
REQ-009 The block SHALL have port done  output  1  one-cycle pulse when results become valid.
REQ-010 The block SHALL have port sum  output  WIDTH  result, held until the next completion.
REQ-011 The block SHALL have port cout  output  1  final carry out of the MSB; for subtract, 1 = no borrow.
REQ-012 The block SHALL have port ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).
REQ-013 The block SHALL have port zero  output  1  high when sum == 0.

Function
REQ-014 The block SHALL implement states IDLE, RUN and DONE, encoded in a registered state variable.
REQ-015 In IDLE with start=1 at a rising edge, the block SHALL load A shift register <= a_in, load B <= (sub ? ~b_in : b_in), load carry flop <= sub, clear the bit counter, and enter RUN.
REQ-016 In RUN, each rising edge SHALL process exactly one bit LSB-first via a 1-bit full adder: s = A[0]^B[0]^c, c_next = majority(A[0],B[0],c).
REQ-017 Each RUN edge SHALL shift A and B right by one, shift s into the MSB of the result shift register, update the carry flop and increment the counter.
REQ-018 The block SHALL capture the carry into the MSB (the carry flop value on the MSB edge) for ovf computation.
REQ-019 On the WIDTH-th RUN edge, the block SHALL enter DONE and register sum, cout, ovf and zero from the final result and carry.
REQ-020 Latency: with start sampled at edge t0, done SHALL be high in the cycle after edge t0+WIDTH, for exactly one cycle.
REQ-021 busy SHALL be high exactly WIDTH cycles, from the cycle after t0 through the cycle of edge t0+WIDTH.
REQ-022 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-023 start SHALL be ignored in RUN and DONE; operands and mode changes during these states SHALL NOT affect the result.
REQ-024 Back-to-back: start held high continuously SHALL begin a new operation in the first IDLE cycle after DONE, one operation per WIDTH+2 cycles.
REQ-025 sum, cout, ovf and zero SHALL change only on the edge entering DONE or on reset; they SHALL be stable at all other times.
REQ-026 Arithmetic SHALL be modulo 2^WIDTH; the carry out of the MSB SHALL be reported only via cout.

Reset
REQ-027 On rst_n=0, regardless of clk, the block SHALL immediately set state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, zero=0, and clear all shift registers, the counter and the carry flop.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst_n deasserts SHALL operate normally.
REQ-029 zero SHALL read 0 after reset until the first completed operation.

Verification (WIDTH=8)
REQ-030 Add: a=0x35, b=0x4A, sub=0 -> sum=0x7F, cout=0, ovf=0, zero=0; done exactly 8 cycles after the start edge; busy high for 8 cycles.
REQ-031 Add wrap: a=0xFF, b=0x01 -> sum=0x00, cout=1, ovf=0, zero=1.
REQ-032 Add overflow: a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
REQ-033 Subtract: 0x10-0x20 -> sum=0xF0, cout=0, ovf=0; then 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
REQ-034 Ignored start: start with 0x01+0x02, then pulse start with 0xAA+0x55 at RUN cycle 3 -> sum=0x03, single done pulse.
REQ-035 Reset mid-op: rst_n low after the 4th RUN edge -> outputs 0 at once, no done pulse; next 0x05+0x06 -> sum=0x0B.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through a single full adder.
// Results and flags are registered on the last bit and held until the next completion.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] res_sr_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;

    logic             bit_s;
    logic             carry_next_s;
    logic [WIDTH-1:0] res_next_s;
    logic             last_bit_s;

    function automatic logic majority3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // One-bit full adder slice and the result word as it will look after this edge
    always_comb begin
        bit_s        = a_sr_r[0] ^ b_sr_r[0] ^ carry_r;
        carry_next_s = majority3(a_sr_r[0], b_sr_r[0], carry_r);
        res_next_s   = {bit_s, res_sr_r[WIDTH-1:1]};
        if (cnt_r == CW'(WIDTH - 1)) begin
            last_bit_s = 1'b1;
        end else begin
            last_bit_s = 1'b0;
        end
    end

    // Control FSM, datapath shift registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            a_sr_r   <= {WIDTH{1'b0}};
            b_sr_r   <= {WIDTH{1'b0}};
            res_sr_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            sum_r    <= {WIDTH{1'b0}};
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
            zero_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + 1: the +1 enters as the initial carry
                        a_sr_r  <= a_in;
                        b_sr_r  <= sub ? ~b_in : b_in;
                        carry_r <= sub;
                        cnt_r   <= {CW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
                    b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
                    res_sr_r <= res_next_s;
                    carry_r  <= carry_next_s;
                    cnt_r    <= cnt_r + CW'(1);
                    if (last_bit_s) begin
                        // carry_r here is the carry into the MSB
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        sum_r   <= res_next_s;
                        cout_r  <= carry_next_s;
                        ovf_r   <= carry_r ^ carry_next_s;
                        zero_r  <= (res_next_s == {WIDTH{1'b0}});
                        state_r <= DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;
    assign zero = zero_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 with hand-computed expected results.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;

    int n_cmp;
    int n_bad;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation, watch 11 cycles after the start edge, then check timing and results.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                          input int glitch, input logic [7:0] e_sum, input logic e_cout,
                          input logic e_ovf, input logic e_zero);
        int done_cnt;
        int first_done;
        int busy_cnt;
        int changes;
        logic [7:0] held;
        done_cnt = 0;
        first_done = 0;
        busy_cnt = 0;
        changes = 0;
        @(negedge clk);
        start = 1'b1;
        a_in = a;
        b_in = b;
        sub = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        held = sum;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (done) begin
                done_cnt = done_cnt + 1;
                if (first_done == 0) first_done = k;
            end
            if (busy) busy_cnt = busy_cnt + 1;
            if (first_done == 0 && !done && sum !== held) changes = changes + 1;
            if (k == glitch) begin
                start = 1'b1;
                a_in = 8'hAA;
                b_in = 8'h55;
                sub = ~s;
            end else if (k == glitch + 1) begin
                start = 1'b0;
                a_in = 8'h00;
                b_in = 8'h00;
            end
        end
        check_val({tag, " done_pulses"}, done_cnt, 32'd1);
        check_val({tag, " latency"}, first_done - 1, 32'd8);
        check_val({tag, " busy_cycles"}, busy_cnt, 32'd8);
        check_val({tag, " early_change"}, changes, 32'd0);
        check_val({tag, " sum"}, {24'd0, sum}, {24'd0, e_sum});
        check_val({tag, " cout"}, {31'd0, cout}, {31'd0, e_cout});
        check_val({tag, " ovf"}, {31'd0, ovf}, {31'd0, e_ovf});
        check_val({tag, " zero"}, {31'd0, zero}, {31'd0, e_zero});
    endtask

    initial begin
        int d_cnt;
        int d_first;
        int d_second;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        sub = 1'b0;
        a_in = 8'h00;
        b_in = 8'h00;
        #12;
        check_val("rst busy", {31'd0, busy}, 32'd0);
        check_val("rst done", {31'd0, done}, 32'd0);
        check_val("rst sum", {24'd0, sum}, 32'd0);
        check_val("rst zero", {31'd0, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("idle zero", {31'd0, zero}, 32'd0);

        run_op("add",      8'h35, 8'h4A, 1'b0, 0, 8'h7F, 1'b0, 1'b0, 1'b0);
        run_op("add_wrap", 8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("add_ovf",  8'h7F, 8'h01, 1'b0, 0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op("sub_neg",  8'h10, 8'h20, 1'b1, 0, 8'hF0, 1'b0, 1'b0, 1'b0);
        run_op("sub_ovf",  8'h80, 8'h01, 1'b1, 0, 8'h7F, 1'b1, 1'b1, 1'b0);
        run_op("ign_start", 8'h01, 8'h02, 1'b0, 3, 8'h03, 1'b0, 1'b0, 1'b0);

        // start held high: completions every WIDTH+2 = 10 cycles
        d_cnt = 0;
        d_first = 0;
        d_second = 0;
        @(negedge clk);
        start = 1'b1;
        a_in = 8'h01;
        b_in = 8'h01;
        sub = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (done) begin
                d_cnt = d_cnt + 1;
                if (d_first == 0) d_first = k;
                else if (d_second == 0) d_second = k;
            end
        end
        start = 1'b0;
        check_val("b2b count", d_cnt, 32'd2);
        check_val("b2b first", d_first, 32'd9);
        check_val("b2b period", d_second - d_first, 32'd10);
        check_val("b2b sum", {24'd0, sum}, 32'h02);
        repeat (12) @(negedge clk);

        // abort after the 4th RUN edge
        start = 1'b1;
        a_in = 8'h33;
        b_in = 8'h44;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("abort sum", {24'd0, sum}, 32'd0);
        check_val("abort busy", {31'd0, busy}, 32'd0);
        check_val("abort flags", {29'd0, cout, ovf, zero}, 32'd0);
        d_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) d_cnt = d_cnt + 1;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) d_cnt = d_cnt + 1;
        end
        check_val("abort no_done", d_cnt, 32'd0);
        run_op("post_rst", 8'h05, 8'h06, 1'b0, 0, 8'h0B, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
